// File: rtl/spi_slave_regif_if.sv
// Bundle of SPI pins and register-side strobes between the mode-0 SPI responder
// and its environment: slave = the responder, master = SPI master plus register block.
interface spi_slave_regif_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
);
   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;
   logic                  wr_vld;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_done;
   logic                  frame_err;
   logic                  busy;

   modport slave (
      input  sclk, cs, mosi, rd_data,
      output miso, wr_vld, wr_addr, wr_data, rd_req, rd_addr, rd_done, frame_err, busy
   );

   modport master (
      output sclk, cs, mosi, rd_data,
      input  miso, wr_vld, wr_addr, wr_data, rd_req, rd_addr, rd_done, frame_err, busy
   );
endinterface

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder: oversamples sclk/cs/mosi, decodes write and read-command
// frames into register strobes, and shifts read data back on miso in a later frame.
module spi_slave_regif #(
   parameter int ADDR_WIDTH  = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int RD_TIMEOUT  = 1023,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   spi_slave_regif_if.slave  bus
);
   localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CMD_W   = 1 + ADDR_WIDTH;
   localparam int CNT_W   = 4;
   localparam int TMO_W   = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, RD_DATA} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q,   cs_prev_d;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_W-1:0]     shift_q, shift_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   miso_q, miso_d;
   logic                   wr_vld_q, wr_vld_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   rd_req_q, rd_req_d;
   logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic                   rd_done_q, rd_done_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q, busy_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // sclk edges only count while the synchronized chip select is asserted
   assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;

      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      tmo_d       = tmo_q;
      miso_d      = miso_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_addr_d   = rd_addr_q;
      wr_vld_d    = 1'b0;
      rd_req_d    = 1'b0;
      rd_done_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d = CMD;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         CMD: begin
            if (cs_rise) begin
               state_d = IDLE;
               if (cnt_q == CNT_W'(FRAME_W) && shift_q[FRAME_W-1]) begin
                  wr_vld_d  = 1'b1;
                  wr_addr_d = shift_q[DATA_WIDTH +: ADDR_WIDTH];
                  wr_data_d = shift_q[DATA_WIDTH-1:0];
               end else if (cnt_q == CNT_W'(CMD_W) && !shift_q[ADDR_WIDTH]) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = shift_q[ADDR_WIDTH-1:0];
                  state_d   = RD_WAIT;
                  tmo_d     = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_d = {shift_q[FRAME_W-2:0], mosi_s};
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         RD_WAIT: begin
            // register block answers one cycle after the request
            if (rd_req_q) tx_d = bus.rd_data;
            if (cs_fall) begin
               state_d = RD_DATA;
               cnt_d   = '0;
               miso_d  = rd_req_q ? bus.rd_data[DATA_WIDTH-1] : tx_q[DATA_WIDTH-1];
            end else if (tmo_q == TMO_W'(RD_TIMEOUT)) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RD_DATA: begin
            if (cs_rise) begin
               state_d = IDLE;
               miso_d  = 1'b0;
               if (cnt_q == CNT_W'(DATA_WIDTH)) rd_done_d = 1'b1;
               else                             frame_err_d = 1'b1;
            end else begin
               if (sclk_rise && cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (sclk_fall) begin
                  tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                  miso_d = tx_q[DATA_WIDTH-2];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         tmo_q       <= '0;
         miso_q      <= 1'b0;
         wr_vld_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         rd_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         tmo_q       <= tmo_d;
         miso_q      <= miso_d;
         wr_vld_q    <= wr_vld_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         rd_done_q   <= rd_done_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.miso      = miso_q;
   assign bus.wr_vld    = wr_vld_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.rd_req    = rd_req_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.rd_done   = rd_done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;
endmodule
